// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and frame-size helpers for the VGA raster timing slice.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Largest frame dimension a 10-bit coordinate can address.
    localparam int COORD_LIMIT = 1024;

    function automatic int h_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bus from the timing generator to the sprite renderers.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t      DrawX;
    coord_t      DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        line_start;
    logic        frame_start;
    logic [7:0]  frame_count;

    modport master (
        output DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync and active-region flags aligned to the position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int VISIBLE    = 640
) (
    input  logic   vga_clk,
    input  logic   reset,
    input  logic   en,
    output logic   wrap,
    output coord_t value,
    output logic   sync_n,
    output logic   active
);

    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_LO = coord_t'(SYNC_START);
    localparam coord_t SYNC_HI = coord_t'(SYNC_START + SYNC_LEN);
    localparam coord_t VIS_END = coord_t'(VISIBLE);

    coord_t next_value;

    // Next position: advance when enabled, fold back to 0 after the last position.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        wrap       = en && (value == LAST);
        next_value = value;
        if (wrap) begin
            next_value = '0;
        end else if (en) begin
            next_value = value + coord_t'(1);
        end
    end

    // Register the position and decode flags from the next position so they line up with it.
    always_ff @(posedge vga_clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values together.
        if (reset) begin
            value  <= LAST;
            sync_n <= 1'b1;
            active <= 1'b0;
        end else begin
            value  <= next_value;
            sync_n <= !((next_value >= SYNC_LO) && (next_value < SYNC_HI));
            active <= (next_value < VIS_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY scan, active-low hs/vs, blank, line/frame strobes, frame counter.
// Optional build macro VGA_PIPE_ALIGN_EN delays hs, vs and blank by one cycle for registered-RGB renderers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic         vga_clk,
    input  logic         reset,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    generate
        if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_size_check
            $error("vga_timing_gen: frame exceeds 10-bit coordinate range");
        end
    endgenerate

    coord_t     h_value, v_value;
    logic       h_wrap, v_wrap;
    logic       h_sync_n, v_sync_n;
    logic       h_active, v_active;
    logic       line_start_q, frame_start_q, frame_seen_q;
    logic [7:0] frame_count_q;
    logic       blank_raw;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .VISIBLE    (H_VISIBLE)
    ) u_h_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (1'b1),
        .wrap    (h_wrap),
        .value   (h_value),
        .sync_n  (h_sync_n),
        .active  (h_active)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .VISIBLE    (V_VISIBLE)
    ) u_v_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .en      (h_wrap),
        .wrap    (v_wrap),
        .value   (v_value),
        .sync_n  (v_sync_n),
        .active  (v_active)
    );

    assign blank_raw = h_active && v_active;

    // Strobes and frame counter; a wrap now means the next position is column 0 (or the origin).
    // The frame entered straight out of reset only arms the counter; later origin entries count.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_seen_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap) begin
                frame_seen_q <= 1'b1;
                if (frame_seen_q) begin
                    frame_count_q <= frame_count_q + 8'd1;
                end
            end
        end
    end

    assign bus.DrawX       = h_value;
    assign bus.DrawY       = v_value;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;

`ifdef VGA_PIPE_ALIGN_EN
    logic hs_q, vs_q, blank_q;

    // Extra stage on the raster-level outputs to match renderers that register RGB a cycle late.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            hs_q    <= h_sync_n;
            vs_q    <= v_sync_n;
            blank_q <= blank_raw;
        end
    end

    assign bus.hs    = hs_q;
    assign bus.vs    = vs_q;
    assign bus.blank = blank_q;
`else
    assign bus.hs    = h_sync_n;
    assign bus.vs    = v_sync_n;
    assign bus.blank = blank_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size 640x480 instance for line-level timing and a
// tiny 8x8 instance (hs low at X 5..6, vs low at Y 5..6, 64-cycle frame) for frame-level checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_PIPE_ALIGN_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic vga_clk = 1'b0;
    logic reset_a;
    logic reset_b;
    int   tests = 0;
    int   fails = 0;
    int   ca    = 0;
    int   cb    = 0;

    vga_timing_if bus_a();
    vga_timing_if bus_b();

    vga_timing_gen u_dut_a (
        .vga_clk (vga_clk),
        .reset   (reset_a),
        .bus     (bus_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_dut_b (
        .vga_clk (vga_clk),
        .reset   (reset_b),
        .bus     (bus_b)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge vga_clk);
        @(negedge vga_clk);
        ca++;
        cb++;
    endtask

    int hs_low, blank_low, ls_cnt;
    int vs_low, hsb_low, blank_hi, fs_cnt, first_vs;

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) step();

        // Held reset.
        check("rst_x",  32'(bus_a.DrawX), 32'd799);
        check("rst_y",  32'(bus_a.DrawY), 32'd524);
        check("rst_hs", 32'(bus_a.hs), 32'd1);
        check("rst_vs", 32'(bus_a.vs), 32'd1);
        check("rst_blank", 32'(bus_a.blank), 32'd0);
        check("rst_ls", 32'(bus_a.line_start), 32'd0);
        check("rst_fs", 32'(bus_a.frame_start), 32'd0);
        check("rst_fc", 32'(bus_a.frame_count), 32'd0);
        check("rst_b_x", 32'(bus_b.DrawX), 32'd7);
        check("rst_b_y", 32'(bus_b.DrawY), 32'd7);

        // First edge after release lands on the origin.
        reset_a = 1'b0;
        reset_b = 1'b0;
        step();
        ca = 0;
        cb = 0;
        check("go_x",  32'(bus_a.DrawX), 32'd0);
        check("go_y",  32'(bus_a.DrawY), 32'd0);
        check("go_blank", 32'(bus_a.blank), (P == 1) ? 32'd0 : 32'd1);
        check("go_ls", 32'(bus_a.line_start), 32'd1);
        check("go_fs", 32'(bus_a.frame_start), 32'd1);
        check("go_fc", 32'(bus_a.frame_count), 32'd0);
        check("go_hs", 32'(bus_a.hs), 32'd1);
        check("go_b_fs", 32'(bus_b.frame_start), 32'd1);

        step();
        check("x1_x",  32'(bus_a.DrawX), 32'd1);
        check("x1_blank", 32'(bus_a.blank), 32'd1);
        check("x1_ls", 32'(bus_a.line_start), 32'd0);
        check("x1_fs", 32'(bus_a.frame_start), 32'd0);

        // Horizontal wrap on line 0.
        while (ca < 799) step();
        check("eol_x", 32'(bus_a.DrawX), 32'd799);
        check("eol_y", 32'(bus_a.DrawY), 32'd0);
        step();
        check("l1_x",  32'(bus_a.DrawX), 32'd0);
        check("l1_y",  32'(bus_a.DrawY), 32'd1);
        check("l1_ls", 32'(bus_a.line_start), 32'd1);
        check("l1_fs", 32'(bus_a.frame_start), 32'd0);

        // Line 10: hs window, blanking region, single line_start.
        while (ca < 8000) step();
        check("l10_x", 32'(bus_a.DrawX), 32'd0);
        check("l10_y", 32'(bus_a.DrawY), 32'd10);
        hs_low = 0;
        blank_low = 0;
        ls_cnt = 0;
        for (int x = 0; x < 800; x++) begin
            if (x > 0) step();
            if (bus_a.hs == 1'b0) hs_low++;
            if (bus_a.blank == 1'b0) blank_low++;
            if (bus_a.line_start == 1'b1) ls_cnt++;
            if (x == 655 + P) check("hs_pre",   32'(bus_a.hs), 32'd1);
            if (x == 656 + P) check("hs_fall",  32'(bus_a.hs), 32'd0);
            if (x == 751 + P) check("hs_last",  32'(bus_a.hs), 32'd0);
            if (x == 752 + P) check("hs_rise",  32'(bus_a.hs), 32'd1);
            if (x == 639 + P) check("blank_on", 32'(bus_a.blank), 32'd1);
            if (x == 640 + P) check("blank_off", 32'(bus_a.blank), 32'd0);
            if (x == 799)     check("blank_799", 32'(bus_a.blank), 32'd0);
            if (x == 0)       check("l10_ls0", 32'(bus_a.line_start), 32'd1);
        end
        check("hs_low_cnt", 32'(hs_low), 32'd96);
        check("blank_low_cnt", 32'(blank_low), 32'd160);
        check("ls_cnt", 32'(ls_cnt), 32'd1);

        // Small instance: reset pulse mid-frame at (5,3).
        while ((cb % 64) != 29) step();
        check("pre_b_x", 32'(bus_b.DrawX), 32'd5);
        check("pre_b_y", 32'(bus_b.DrawY), 32'd3);
        check("pre_b_fc", 32'(bus_b.frame_count), 32'((cb / 64) % 256));
        reset_b = 1'b1;
        step();
        check("mid_rst_x", 32'(bus_b.DrawX), 32'd7);
        check("mid_rst_y", 32'(bus_b.DrawY), 32'd7);
        check("mid_rst_hs", 32'(bus_b.hs), 32'd1);
        check("mid_rst_vs", 32'(bus_b.vs), 32'd1);
        check("mid_rst_blank", 32'(bus_b.blank), 32'd0);
        check("mid_rst_fc", 32'(bus_b.frame_count), 32'd0);
        reset_b = 1'b0;
        step();
        cb = 0;
        check("restart_x", 32'(bus_b.DrawX), 32'd0);
        check("restart_y", 32'(bus_b.DrawY), 32'd0);
        check("restart_fs", 32'(bus_b.frame_start), 32'd1);
        check("restart_ls", 32'(bus_b.line_start), 32'd1);
        check("restart_fc", 32'(bus_b.frame_count), 32'd0);

        // One full small frame: sync, blank and strobe totals plus wrap points.
        vs_low = 0;
        hsb_low = 0;
        blank_hi = 0;
        fs_cnt = 0;
        first_vs = -1;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) step();
            if (bus_b.vs == 1'b0) begin
                vs_low++;
                if (first_vs < 0) first_vs = i;
            end
            if (bus_b.hs == 1'b0) hsb_low++;
            if (bus_b.blank == 1'b1) blank_hi++;
            if (bus_b.frame_start == 1'b1) fs_cnt++;
            if (i == 31) begin
                check("wrap_pre_x", 32'(bus_b.DrawX), 32'd7);
                check("wrap_pre_y", 32'(bus_b.DrawY), 32'd3);
            end
            if (i == 32) begin
                check("wrap_post_x", 32'(bus_b.DrawX), 32'd0);
                check("wrap_post_y", 32'(bus_b.DrawY), 32'd4);
            end
            if (i == 63) begin
                check("last_x", 32'(bus_b.DrawX), 32'd7);
                check("last_y", 32'(bus_b.DrawY), 32'd7);
            end
        end
        check("vs_low_cnt", 32'(vs_low), 32'd16);
        check("vs_first", 32'(first_vs), 32'(40 + P));
        check("hs_b_low_cnt", 32'(hsb_low), 32'd16);
        check("blank_b_hi_cnt", 32'(blank_hi), 32'd16);
        check("fs_per_frame", 32'(fs_cnt), 32'd1);
        step();
        check("f1_x",  32'(bus_b.DrawX), 32'd0);
        check("f1_y",  32'(bus_b.DrawY), 32'd0);
        check("f1_fs", 32'(bus_b.frame_start), 32'd1);
        check("f1_ls", 32'(bus_b.line_start), 32'd1);
        check("f1_fc", 32'(bus_b.frame_count), 32'd1);

        // Frame counter wrap 255 -> 0.
        while (cb < 256 * 64 - 1) step();
        check("fc_255", 32'(bus_b.frame_count), 32'd255);
        step();
        check("fc_wrap", 32'(bus_b.frame_count), 32'd0);
        check("fc_wrap_fs", 32'(bus_b.frame_start), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
